// File: rtl/turf_ram_arbiter.sv
// ============================================================================
// Module   : turf_ram_arbiter
// Brief    : Single-port owner of the 3-bit turf RAM. Interleaves four
//            per-tick player trail writes with a pausable full-field scan
//            read. Trail writes always pre-empt the scan.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module turf_ram_arbiter #(
    parameter logic [14:0] LAST_ADDR = 15'h4F7F,
    parameter logic [2:0]  P1_COL    = 3'b001,
    parameter logic [2:0]  P2_COL    = 3'b010,
    parameter logic [2:0]  P3_COL    = 3'b100,
    parameter logic [2:0]  P4_COL    = 3'b110
) (
    input  logic        clock25,
    input  logic        reset,
    input  logic        running,
    input  logic        tick,
    input  logic [14:0] p1,
    input  logic [14:0] p2,
    input  logic [14:0] p3,
    input  logic [14:0] p4,
    input  logic        scan_req,
    output logic        scan_busy,
    output logic        scan_valid,
    output logic [14:0] scan_addr,
    output logic [2:0]  scan_data,
    output logic        scan_done,
    output logic [14:0] address,
    output logic        wren,
    output logic [2:0]  data_to_ram,
    input  logic [2:0]  ram_output,
    output logic        overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;

    logic [3:0]  r_pending;
    logic [1:0]  r_rr_ptr;
    logic [1:0]  r_base;
    logic [14:0] r_pos [4];
    logic        r_overrun;

    logic [14:0] r_ptr;
    logic        r_rd_valid;
    logic [14:0] r_rd_addr;

    logic [14:0] r_bus_addr;
    logic [2:0]  r_bus_data;

    logic        w_tick_accept;
    logic        w_wr_cycle;
    logic        w_rd_issue;
    logic [1:0]  w_sel;
    logic [2:0]  w_sel_col;

    assign w_tick_accept = tick & running;
    assign w_wr_cycle    = |r_pending;

    // Pick the first pending player, searching upward (mod 4) from the tick's base
    always_comb begin
        logic [1:0] v_idx;
        logic       v_found;
        w_sel   = r_base;
        v_found = 1'b0;
        v_idx   = r_base;
        for (int i = 0; i < 4; i++) begin
            v_idx = r_base + 2'(i);
            if (!v_found && r_pending[v_idx]) begin
                w_sel   = v_idx;
                v_found = 1'b1;
            end
        end
    end

    // Colour for the selected player
    always_comb begin
        case (w_sel)
            2'd0:    w_sel_col = P1_COL;
            2'd1:    w_sel_col = P2_COL;
            2'd2:    w_sel_col = P3_COL;
            default: w_sel_col = P4_COL;
        endcase
    end

    // Tick capture, pending-write bookkeeping and sticky overrun flag
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            r_pending <= 4'b0000;
            r_rr_ptr  <= 2'd0;
            r_base    <= 2'd0;
            r_overrun <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_pos[i] <= 15'd0;
            end
        end else if (w_tick_accept) begin
            // A new tick replaces any unserviced writes from the previous one
            r_pos[0]  <= p1;
            r_pos[1]  <= p2;
            r_pos[2]  <= p3;
            r_pos[3]  <= p4;
            r_pending <= 4'b1111;
            r_rr_ptr  <= r_rr_ptr + 2'd1;
            r_base    <= r_rr_ptr + 2'd1;
            if (w_wr_cycle) begin
                r_overrun <= 1'b1;
            end
        end else if (w_wr_cycle) begin
            r_pending[w_sel] <= 1'b0;
        end
    end

    // Scan state register
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Scan next-state logic; DRAIN is the single cycle in which the last read returns
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (scan_req) w_state_next = S_RUN;
            S_RUN:   if (w_rd_issue && (r_ptr == LAST_ADDR)) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Scan/bus outputs: writes own the bus whenever any are pending
    always_comb begin
        scan_busy   = (r_state != S_IDLE);
        w_rd_issue  = (r_state == S_RUN) && !w_wr_cycle;
        wren        = w_wr_cycle;
        address     = r_bus_addr;
        data_to_ram = r_bus_data;
        if (w_wr_cycle) begin
            address     = r_pos[w_sel];
            data_to_ram = w_sel_col;
        end else if (w_rd_issue) begin
            address = r_ptr;
        end
    end

    // Scan pointer: cleared on scan start, advanced only on issued reads
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            r_ptr <= 15'd0;
        end else if ((r_state == S_IDLE) && scan_req) begin
            r_ptr <= 15'd0;
        end else if (w_rd_issue) begin
            r_ptr <= r_ptr + 15'd1;
        end
    end

    // Read return tracking and last-driven bus values for idle cycles
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_addr  <= 15'd0;
            r_bus_addr <= 15'd0;
            r_bus_data <= 3'd0;
        end else begin
            r_rd_valid <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_addr <= r_ptr;
            end
            if (w_wr_cycle) begin
                r_bus_addr <= r_pos[w_sel];
                r_bus_data <= w_sel_col;
            end else if (w_rd_issue) begin
                r_bus_addr <= r_ptr;
            end
        end
    end

    assign scan_valid = r_rd_valid;
    assign scan_addr  = r_rd_addr;
    assign scan_data  = r_rd_valid ? ram_output : 3'd0;
    assign scan_done  = r_rd_valid && (r_rd_addr == LAST_ADDR);
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_turf_ram_arbiter.sv
// ============================================================================
// Module   : tb_turf_ram_arbiter
// Brief    : Scoreboard bench for turf_ram_arbiter with a behavioural RAM,
//            a queue-based write/scan reference model and a shadow field.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_turf_ram_arbiter;

    localparam logic [14:0] LAST = 15'h4F7F;

    typedef struct {
        logic [14:0] a;
        logic [2:0]  d;
    } wr_t;

    logic        clock25 = 1'b0;
    logic        reset;
    logic        running;
    logic        tick;
    logic [14:0] p1, p2, p3, p4;
    logic        scan_req;
    logic        scan_busy, scan_valid, scan_done, wren, overrun;
    logic [14:0] scan_addr, address;
    logic [2:0]  scan_data, data_to_ram, ram_output;

    turf_ram_arbiter dut (
        .clock25     (clock25),
        .reset       (reset),
        .running     (running),
        .tick        (tick),
        .p1          (p1),
        .p2          (p2),
        .p3          (p3),
        .p4          (p4),
        .scan_req    (scan_req),
        .scan_busy   (scan_busy),
        .scan_valid  (scan_valid),
        .scan_addr   (scan_addr),
        .scan_data   (scan_data),
        .scan_done   (scan_done),
        .address     (address),
        .wren        (wren),
        .data_to_ram (data_to_ram),
        .ram_output  (ram_output),
        .overrun     (overrun)
    );

    always #5 clock25 = ~clock25;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          req_cyc = 0;
    int          done_cyc = 0;
    logic [2:0]  d105 = 3'd0;

    logic [2:0]  mem    [32768];
    logic [2:0]  shadow [32768];
    logic [2:0]  cols   [4] = '{3'b001, 3'b010, 3'b100, 3'b110};

    wr_t         wq[$];
    logic [14:0] sq[$];
    int          m_rr = 0;
    bit          m_over = 1'b0;
    bit          m_scan_active = 1'b0;

    always @(posedge clock25) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Synchronous-read RAM, preloaded with addr[2:0]
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 3'(i);
        ram_output = 3'd0;
        forever begin
            @(posedge clock25);
            ram_output <= mem[address];
            if (wren) mem[address] = data_to_ram;
        end
    end

    // Monitor: pops expected scan returns and writes whenever the DUT presents them
    initial begin
        logic [14:0] ea;
        wr_t         e;
        for (int i = 0; i < 32768; i++) shadow[i] = 3'(i);
        forever begin
            @(negedge clock25);
            if (scan_valid) begin
                if (sq.size() == 0) begin
                    chk("scan_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    ea = sq.pop_front();
                    chk("scan_addr", 32'(scan_addr), 32'(ea));
                    chk("scan_data", 32'(scan_data), 32'(shadow[ea]));
                    chk("scan_done", 32'(scan_done), 32'(ea == LAST));
                    if (ea == 15'h0105) d105 = scan_data;
                    if (ea == LAST) begin
                        done_cyc      = cyc;
                        m_scan_active = 1'b0;
                    end
                end
            end else if (scan_done) begin
                chk("scan_done_without_valid", 32'd1, 32'd0);
            end
            chk("wren", 32'(wren), 32'(wq.size() != 0));
            if (wren && wq.size() != 0) begin
                e = wq.pop_front();
                chk("wr_addr", 32'(address), 32'(e.a));
                chk("wr_data", 32'(data_to_ram), 32'(e.d));
                shadow[e.a] = e.d;
            end
        end
    end

    // One stimulus cycle; the model is updated right after the sampling edge
    task automatic stim(input bit tk, input bit run, input bit sreq,
                        input logic [14:0] a, input logic [14:0] b,
                        input logic [14:0] c, input logic [14:0] d);
        logic [14:0] pos [4];
        int k;
        @(negedge clock25);
        tick = tk; running = run; scan_req = sreq;
        p1 = a; p2 = b; p3 = c; p4 = d;
        if (sreq) req_cyc = cyc;
        @(posedge clock25);
        #1;
        tick = 1'b0; scan_req = 1'b0;
        if (tk && run) begin
            m_over = m_over | (wq.size() != 0);
            wq.delete();
            m_rr = (m_rr + 1) % 4;
            pos = '{a, b, c, d};
            for (int i = 0; i < 4; i++) begin
                k = (m_rr + i) % 4;
                wq.push_back('{a: pos[k], d: cols[k]});
            end
            chk("overrun", 32'(overrun), 32'(m_over));
        end
        if (sreq && !m_scan_active) begin
            for (int x = 0; x <= int'(LAST); x++) sq.push_back(15'(x));
            m_scan_active = 1'b1;
            chk("scan_busy_start", 32'(scan_busy), 32'd1);
        end
    endtask

    task automatic rnd_tick(input bit run);
        stim(1'b1, run, 1'b0, 15'($urandom), 15'($urandom), 15'($urandom), 15'($urandom));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (m_scan_active && n < budget) begin
            @(posedge clock25);
            n++;
        end
        #1;
        if (m_scan_active) chk("scan_timeout", 32'd1, 32'd0);
        else chk("scan_busy_after_done", 32'(scan_busy), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_scan_busy"}, 32'(scan_busy), 32'd0);
        chk({tag, "_scan_valid"}, 32'(scan_valid), 32'd0);
        chk({tag, "_scan_addr"}, 32'(scan_addr), 32'd0);
        chk({tag, "_scan_data"}, 32'(scan_data), 32'd0);
        chk({tag, "_scan_done"}, 32'(scan_done), 32'd0);
        chk({tag, "_address"}, 32'(address), 32'd0);
        chk({tag, "_wren"}, 32'(wren), 32'd0);
        chk({tag, "_data_to_ram"}, 32'(data_to_ram), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int r;
        reset = 1'b1; running = 1'b1; tick = 1'b0; scan_req = 1'b0;
        p1 = '0; p2 = '0; p3 = '0; p4 = '0;
        #1;
        check_zero("reset");
        repeat (3) @(negedge clock25);
        reset = 1'b0;

        // First tick: rr_ptr 1 -> p2,p3,p4,p1
        stim(1'b1, 1'b1, 1'b0, 15'h4EF6, 15'h0082, 15'h4E82, 15'h00F6);
        repeat (6) @(posedge clock25);
        rnd_tick(1'b1);
        repeat (6) @(posedge clock25);
        rnd_tick(1'b1);
        repeat (6) @(posedge clock25);
        // rr_ptr 0: p1 then p3 hit the same cell, p3 must win
        stim(1'b1, 1'b1, 1'b0, 15'h0105, 15'h0200, 15'h0105, 15'h0300);
        repeat (6) @(posedge clock25);

        // Clean scan: latency and contents
        stim(1'b0, 1'b1, 1'b1, '0, '0, '0, '0);
        wait_done(21000);
        chk("scan_latency", 32'(done_cyc - req_cyc), 32'(int'(LAST) + 2));
        chk("collision_cell", 32'(d105), 32'd4);

        // Overrun: second tick two cycles after the first
        rnd_tick(1'b1);
        @(posedge clock25);
        rnd_tick(1'b1);
        repeat (10) @(posedge clock25);
        #1;
        chk("overrun_sticky", 32'(overrun), 32'(m_over));

        // Scan with simultaneous tick, a tick near ptr=100 and random ticks
        stim(1'b1, 1'b1, 1'b1, 15'($urandom), 15'($urandom), 15'($urandom), 15'($urandom));
        repeat (100) @(posedge clock25);
        rnd_tick(1'b1);
        guard = 0;
        while (m_scan_active && guard < 100) begin
            repeat ($urandom_range(3, 600)) @(posedge clock25);
            r = $urandom_range(0, 9);
            rnd_tick(r != 0);
            if (r == 1) begin
                @(posedge clock25);
                rnd_tick(1'b1);
            end
            guard++;
        end
        wait_done(25000);

        // Reset during a scan with writes pending
        repeat (4) @(posedge clock25);
        stim(1'b0, 1'b1, 1'b1, '0, '0, '0, '0);
        repeat (50) @(posedge clock25);
        rnd_tick(1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        wq.delete();
        sq.delete();
        m_scan_active = 1'b0;
        m_over = 1'b0;
        m_rr = 0;
        repeat (2) @(negedge clock25);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rnd_tick(1'b0);
            repeat (3) @(posedge clock25);
        end
        #1;
        chk("idle_after_reset_busy", 32'(scan_busy), 32'd0);
        chk("idle_after_reset_wren", 32'(wren), 32'd0);
        // rr_ptr must still be at its reset value: order p2,p3,p4,p1
        rnd_tick(1'b1);
        repeat (8) @(posedge clock25);
        #1;
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        chk("scan_queue_drained", 32'(sq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/turf_ram_arbiter.md
Name: turf_ram_arbiter

Overview:
- Single-port owner of the 3-bit-per-cell turf RAM (15-bit address, row[14:7]/col[6:0] packing).
- Shares the RAM between two requesters:
  - four player trail writers, triggered once per movement tick;
  - one full-field scan reader, used by scoring/ranking logic.
- Trail writes always pre-empt the scan. The scan pauses and resumes without skipping or repeating any cell.
- Sits between the movement logic and the RAM instance. It replaces ad-hoc write/read sequencing.

Parameters:
- LAST_ADDR, 15'h4F7F, final address visited by a scan (inclusive).
- P1_COL, 3'b001, colour written for player 1.
- P2_COL, 3'b010, colour written for player 2.
- P3_COL, 3'b100, colour written for player 3.
- P4_COL, 3'b110, colour written for player 4.

Ports:
- clock25  in  1  block clock; all registers on posedge.
- reset  in  1  asynchronous, active-high reset.
- running  in  1  game active; ticks are ignored when low.
- tick  in  1  one-cycle movement pulse; latches p1..p4 and arms four writes.
- p1  in  15  player 1 position, {row[7:0],col[6:0]}.
- p2  in  15  player 2 position.
- p3  in  15  player 3 position.
- p4  in  15  player 4 position.
- scan_req  in  1  start a full-field read scan; ignored while scan_busy.
- scan_busy  out  1  scan in progress.
- scan_valid  out  1  scan_data/scan_addr valid this cycle.
- scan_addr  out  15  address whose contents are on scan_data.
- scan_data  out  3  RAM contents for scan_addr.
- scan_done  out  1  one-cycle pulse, coincident with scan_valid for LAST_ADDR.
- address  out  15  RAM address.
- wren  out  1  RAM write enable.
- data_to_ram  out  3  RAM write data.
- ram_output  in  3  RAM read data, valid one cycle after address is issued.
- overrun  out  1  sticky: a tick arrived before the previous tick's writes finished.

Behaviour:
- Reset values: all outputs 0, pending[3:0]=0, rr_ptr=0, scan pointer 0. An in-flight scan is aborted with no scan_done. Reset takes effect immediately (asynchronous).
- Tick capture: a tick with running=1 latches p1..p4, sets pending=4'b1111 and advances rr_ptr by 1 (mod 4). A tick with running=0 changes nothing; writes already pending still complete.
- Write service: each cycle with pending!=0 is a write cycle. The block issues the lowest-order pending player, searching upward from the rr_ptr value captured at the tick (mod 4).
  - Drives address=latched pos, data_to_ram=Pn_COL, wren=1; clears that pending bit.
  - Tick at edge t gives write cycles t+1..t+4, back to back.
  - Collision (two players on the same cell): both writes are issued; the later in round-robin order wins.
- Overrun: a tick arriving while pending!=0 sets overrun=1 (sticky until reset). New positions are latched and pending is forced to 4'b1111. Unserviced old writes are dropped.
- Scan FSM states:
  - S_IDLE: on scan_req, go to S_RUN with ptr=0; scan_busy=1 from the next cycle.
  - S_RUN: in any cycle with no write pending, drive address=ptr, wren=0, then ptr+1. After issuing LAST_ADDR, go to S_DRAIN.
  - S_DRAIN: wait for the final read return, then go to S_IDLE; scan_busy drops the cycle after scan_done.
- Read return: a read issued in cycle c produces scan_valid=1, scan_addr=c's address and scan_data=ram_output in cycle c+1. This happens even if cycle c+1 is a write cycle.
- Pre-emption: write cycles only stall ptr. Every address 0..LAST_ADDR yields exactly one scan_valid, in ascending order.
- Scan latency: with no writes, LAST_ADDR+2 cycles from scan_req to scan_done.
- Idle bus: with no write and no scan read, wren=0 and address/data_to_ram hold their last values.
- Simultaneous tick and scan_req: both are accepted. Writes go first, and the scan's first read follows the last write.

Test Plan:
- Reset, running=1, tick with p1=15'h4EF6, p2=15'h0082, p3=15'h4E82, p4=15'h00F6 -> wren=1 for exactly 4 consecutive cycles. rr_ptr=1 gives order p2,p3,p4,p1 with data 010,100,110,001; overrun=0.
- Preload the RAM model with addr[2:0], then scan_req, no ticks -> 20352 scan_valid pulses, addresses 0..0x4F7F ascending, each data=addr[2:0]. scan_done coincides with addr 0x4F7F, 0x4F81 cycles after scan_req.
- Tick mid-scan at ptr=100 -> 4 write cycles, ptr holds at 100, then resumes at 100. No address is missing or duplicated, and the read issued just before the tick still returns.
- p1 and p3 both at 15'h0105, tick with rr_ptr=0 -> writes order p1 then p3; a subsequent scan reads 3'b100 at 0x0105.
- Second tick 2 cycles after the first -> overrun=1 and stays 1. Exactly 2+4 write cycles occur, and the last four use the second tick's positions.
- Assert reset during a scan and pending writes, with running=0 ticks after reset -> all outputs 0 immediately, no scan_done. Ticks produce no wren, and pending stays 0.
